arb_rr_mux: RTL and testbench

ARB_RR_MUX -- requirements
Module: arb_rr_mux

---
 rtl/arb_pkg.sv | 14 +
 rtl/arb_rr_mux_if.sv | 25 ++
 rtl/mux_key.sv | 22 ++
 rtl/arb_rr_mux.sv | 106 ++++++++++
 tb/tb_arb_rr_mux.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter/mux.
package arb_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } arb_state_e;

   // Index width for n requesters, never narrower than one bit.
   function automatic int id_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/arb_rr_mux_if.sv
// Request-side and output-side handshake bundle of the round-robin arbiter/mux.
interface arb_rr_mux_if #(
   parameter int REQ_NUM    = 4,
   parameter int DATA_WIDTH = 8
);
   localparam int ID_WIDTH = arb_pkg::id_width(REQ_NUM);

   logic [REQ_NUM-1:0]            i_req_valid;
   logic [REQ_NUM-1:0]            o_req_ready;
   logic [REQ_NUM*DATA_WIDTH-1:0] i_req_data;
   logic                          o_val_valid;
   logic                          i_val_ready;
   logic [DATA_WIDTH-1:0]         o_val_data;
   logic [ID_WIDTH-1:0]           o_val_id;

   modport slave (
      input  i_req_valid, i_req_data, i_val_ready,
      output o_req_ready, o_val_valid, o_val_data, o_val_id
   );

   modport master (
      output i_req_valid, i_req_data, i_val_ready,
      input  o_req_ready, o_val_valid, o_val_data, o_val_id
   );
endinterface

// File: rtl/mux_key.sv
// Key-addressed multiplexer: returns the value of the LUT entry whose key matches.
module mux_key #(
   parameter int KEY_NUM   = 4,
   parameter int KEY_WIDTH = 2,
   parameter int VAL_WIDTH = 8
) (
   input  logic [KEY_WIDTH-1:0]                   i_key,
   input  logic [KEY_NUM*(KEY_WIDTH+VAL_WIDTH)-1:0] i_lut,
   output logic [VAL_WIDTH-1:0]                   o_val
);
   localparam int PAIR_W = KEY_WIDTH + VAL_WIDTH;

   // Keys are unique, so OR-ing the masked entries yields the single match.
   always_comb begin
      o_val = '0;
      for (int k = 0; k < KEY_NUM; k++) begin
         o_val = o_val | ({VAL_WIDTH{i_lut[k*PAIR_W+VAL_WIDTH +: KEY_WIDTH] == i_key}}
                          & i_lut[k*PAIR_W +: VAL_WIDTH]);
      end
   end

endmodule

// File: rtl/arb_rr_mux.sv
// Round-robin arbiter feeding a one-entry output register with a valid/ready handshake.
module arb_rr_mux
   import arb_pkg::*;
#(
   parameter int REQ_NUM    = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   arb_rr_mux_if.slave  bus
);
   localparam int ID_WIDTH = id_width(REQ_NUM);
   localparam int PAIR_W   = ID_WIDTH + DATA_WIDTH;

   arb_state_e             state_q, state_d;
   logic [ID_WIDTH-1:0]    ptr_q, ptr_d;
   logic [ID_WIDTH-1:0]    val_id_q, val_id_d;
   logic [DATA_WIDTH-1:0]  val_data_q, val_data_d;

   logic [ID_WIDTH:0]      sum_s;
   logic [ID_WIDTH-1:0]    cand_s;
   logic                   hit_s;
   logic                   found_s;
   logic [ID_WIDTH-1:0]    winner_s;
   logic [ID_WIDTH-1:0]    ptr_next_s;
   logic                   load_s;
   logic [REQ_NUM-1:0]     req_ready_s;
   logic [REQ_NUM*PAIR_W-1:0] lut_s;
   logic [DATA_WIDTH-1:0]  win_data_s;

   // Scan upward from ptr, wrapping at REQ_NUM-1; the first valid requester wins.
   always_comb begin
      found_s  = 1'b0;
      winner_s = '0;
      sum_s    = '0;
      cand_s   = '0;
      hit_s    = 1'b0;
      for (int off = 0; off < REQ_NUM; off++) begin
         sum_s    = {1'b0, ptr_q} + (ID_WIDTH+1)'(off);
         sum_s    = (sum_s >= (ID_WIDTH+1)'(REQ_NUM)) ? (sum_s - (ID_WIDTH+1)'(REQ_NUM)) : sum_s;
         cand_s   = sum_s[ID_WIDTH-1:0];
         hit_s    = ~found_s & bus.i_req_valid[cand_s];
         winner_s = hit_s ? cand_s : winner_s;
         found_s  = found_s | hit_s;
      end
   end

   assign load_s      = found_s & ((state_q == EMPTY) | bus.i_val_ready) & ~i_rst;
   assign req_ready_s = load_s ? (REQ_NUM'(1'b1) << winner_s) : '0;
   assign ptr_next_s  = (winner_s == ID_WIDTH'(REQ_NUM - 1)) ? '0 : (winner_s + ID_WIDTH'(1'b1));

   for (genvar k = 0; k < REQ_NUM; k++) begin : g_lut
      assign lut_s[k*PAIR_W +: PAIR_W] = {ID_WIDTH'(k), bus.i_req_data[k*DATA_WIDTH +: DATA_WIDTH]};
   end

   mux_key #(
      .KEY_NUM   (REQ_NUM),
      .KEY_WIDTH (ID_WIDTH),
      .VAL_WIDTH (DATA_WIDTH)
   ) u_mux_key (
      .i_key (winner_s),
      .i_lut (lut_s),
      .o_val (win_data_s)
   );

   // Next-state: a load always (re)fills the register; otherwise FULL drains on ready.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      val_id_d   = val_id_q;
      val_data_d = val_data_q;
      if (load_s) begin
         state_d    = FULL;
         ptr_d      = ptr_next_s;
         val_id_d   = winner_s;
         val_data_d = win_data_s;
      end else begin
         case (state_q)
            EMPTY:   state_d = EMPTY;
            FULL:    state_d = bus.i_val_ready ? EMPTY : FULL;
            default: state_d = EMPTY;
         endcase
      end
   end

   // State and output registers; reset discards any held payload.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= EMPTY;
         ptr_q      <= '0;
         val_id_q   <= '0;
         val_data_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         val_id_q   <= val_id_d;
         val_data_q <= val_data_d;
      end
   end

   assign bus.o_req_ready = req_ready_s;
   assign bus.o_val_valid = (state_q == FULL);
   assign bus.o_val_data  = val_data_q;
   assign bus.o_val_id    = val_id_q;

endmodule

// File: tb/tb_arb_rr_mux.sv
// Directed vector table plus randomized traffic checked against a behavioural model.
module tb_arb_rr_mux;
   localparam int N  = 4;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   arb_rr_mux_if #(.REQ_NUM(N), .DATA_WIDTH(DW)) bus ();

   arb_rr_mux #(.REQ_NUM(N), .DATA_WIDTH(DW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   typedef struct {
      logic        rst;
      logic [3:0]  valid;
      logic [31:0] data;
      logic        vready;
      logic [3:0]  e_ready;
      logic        chk_vv;
      logic        e_vv;
      logic        chk_pl;
      logic [1:0]  e_id;
      logic [7:0]  e_data;
   } vec_t;

   vec_t vecs[$];
   int   checks   = 0;
   int   failures = 0;

   // reference model state
   bit       m_full;
   int       m_id;
   int       m_ptr;
   bit [7:0] m_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [3:0] v, input logic [31:0] d, input logic vr,
                      input logic [3:0] er, input logic cvv, input logic evv,
                      input logic cpl, input logic [1:0] eid, input logic [7:0] ed);
      vec_t t;
      t.rst = r; t.valid = v; t.data = d; t.vready = vr; t.e_ready = er;
      t.chk_vv = cvv; t.e_vv = evv; t.chk_pl = cpl; t.e_id = eid; t.e_data = ed;
      vecs.push_back(t);
   endtask

   function automatic int pick(input logic [3:0] v, input int p);
      for (int off = 0; off < N; off++) begin
         if (v[(p + off) % N]) return (p + off) % N;
      end
      return -1;
   endfunction

   function automatic logic [3:0] model_ready(input logic r, input logic [3:0] v, input logic vr);
      int w;
      w = pick(v, m_ptr);
      if (r || w < 0 || (m_full && !vr)) return 4'd0;
      return 4'(1 << w);
   endfunction

   task automatic model_step(input logic r, input logic [3:0] v, input logic [31:0] d, input logic vr);
      int w;
      w = pick(v, m_ptr);
      if (r) begin
         m_full = 1'b0; m_id = 0; m_ptr = 0; m_data = 8'd0;
      end else if (w >= 0 && (!m_full || vr)) begin
         m_full = 1'b1; m_id = w; m_data = d[w*8 +: 8]; m_ptr = (w + 1) % N;
      end else if (m_full && vr) begin
         m_full = 1'b0;
      end
   endtask

   task automatic drive(input logic r, input logic [3:0] v, input logic [31:0] d, input logic vr);
      @(negedge clk);
      rst             = r;
      bus.i_req_valid = v;
      bus.i_req_data  = d;
      bus.i_val_ready = vr;
      #1;
   endtask

   localparam logic [31:0] D  = 32'h44332211;
   localparam logic [31:0] BP = 32'h44A52211;
   localparam logic [31:0] DR = 32'h44333C11;

   initial begin
      logic        r, vr;
      logic [3:0]  v;
      logic [31:0] d;

      bus.i_req_valid = 4'd0;
      bus.i_req_data  = 32'd0;
      bus.i_val_ready = 1'b0;

      // reset held two cycles with every requester valid
      add(1'b1, 4'hF, D, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
      add(1'b1, 4'hF, D, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 2'd0, 8'h00);
      // fairness: all valid, ready high
      add(1'b0, 4'hF, D, 1'b1, 4'h1, 1'b1, 1'b0, 1'b1, 2'd0, 8'h00);
      add(1'b0, 4'hF, D, 1'b1, 4'h2, 1'b1, 1'b1, 1'b1, 2'd0, 8'h11);
      add(1'b0, 4'hF, D, 1'b1, 4'h4, 1'b1, 1'b1, 1'b1, 2'd1, 8'h22);
      add(1'b0, 4'hF, D, 1'b1, 4'h8, 1'b1, 1'b1, 1'b1, 2'd2, 8'h33);
      add(1'b0, 4'hF, D, 1'b1, 4'h1, 1'b1, 1'b1, 1'b1, 2'd3, 8'h44);
      add(1'b0, 4'hF, D, 1'b1, 4'h2, 1'b1, 1'b1, 1'b1, 2'd0, 8'h11);
      add(1'b0, 4'hF, D, 1'b1, 4'h4, 1'b1, 1'b1, 1'b1, 2'd1, 8'h22);
      add(1'b0, 4'hF, D, 1'b1, 4'h8, 1'b1, 1'b1, 1'b1, 2'd2, 8'h33);
      add(1'b0, 4'h0, D, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 2'd3, 8'h44);
      // backpressure: grant req 2 (0xA5) then ready low for three cycles
      add(1'b0, 4'h4, BP, 1'b0, 4'h4, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
      add(1'b0, 4'h4, BP, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 2'd2, 8'hA5);
      add(1'b0, 4'h4, BP, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 2'd2, 8'hA5);
      add(1'b0, 4'h4, BP, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 2'd2, 8'hA5);
      // wrap: ptr=3, only 0 and 1 valid
      add(1'b0, 4'h3, D, 1'b1, 4'h1, 1'b1, 1'b1, 1'b1, 2'd2, 8'hA5);
      add(1'b0, 4'h3, D, 1'b1, 4'h2, 1'b1, 1'b1, 1'b1, 2'd0, 8'h11);
      add(1'b0, 4'h0, D, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 2'd1, 8'h22);
      // drain to empty: single request id 1 (0x3C)
      add(1'b0, 4'h2, DR, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
      add(1'b0, 4'h0, DR, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 2'd1, 8'h3C);
      add(1'b0, 4'h0, DR, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
      // mid-operation reset while FULL and stalled; ptr must return to 0
      add(1'b0, 4'h4, D, 1'b0, 4'h4, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
      add(1'b0, 4'h0, D, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 2'd2, 8'h33);
      add(1'b1, 4'hF, D, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 2'd2, 8'h33);
      add(1'b0, 4'hF, D, 1'b1, 4'h1, 1'b1, 1'b0, 1'b1, 2'd0, 8'h00);
      add(1'b0, 4'h0, D, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 2'd0, 8'h11);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].vready);
         check($sformatf("vec%0d ready", i), 32'(bus.o_req_ready), 32'(vecs[i].e_ready));
         if (vecs[i].chk_vv)
            check($sformatf("vec%0d valid", i), 32'(bus.o_val_valid), 32'(vecs[i].e_vv));
         if (vecs[i].chk_pl) begin
            check($sformatf("vec%0d id", i), 32'(bus.o_val_id), 32'(vecs[i].e_id));
            check($sformatf("vec%0d data", i), 32'(bus.o_val_data), 32'(vecs[i].e_data));
         end
         model_step(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].vready);
      end

      for (int c = 0; c < 600; c++) begin
         r  = ($urandom_range(0, 39) == 0);
         v  = 4'($urandom_range(0, 15));
         d  = $urandom;
         vr = ($urandom_range(0, 3) != 0);
         drive(r, v, d, vr);
         check($sformatf("rnd%0d ready", c), 32'(bus.o_req_ready), 32'(model_ready(r, v, vr)));
         check($sformatf("rnd%0d valid", c), 32'(bus.o_val_valid), 32'(m_full));
         if (m_full) begin
            check($sformatf("rnd%0d id", c), 32'(bus.o_val_id), 32'(m_id));
            check($sformatf("rnd%0d data", c), 32'(bus.o_val_data), 32'(m_data));
         end
         model_step(r, v, d, vr);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
